// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// Single-clock parametrised FIFO used as the TX/RX byte buffer of the I2C
// master and slave blocks. It provides an occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// synchronous flush.
//
// Configuration macro:
//   SYNC_FIFO_FWFT_EN  - when defined, the FIFO runs in first-word
//                        fall-through mode: data_o always shows the head word
//                        (0 when empty) and read_inc_i pops it. When
//                        undefined, data_o is a register loaded on each
//                        accepted read (1-cycle read latency).
//
// Parameters:
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  address bits, DEPTH = 2**ADDR_WIDTH
//   AF_LEVEL    almost_full_o when count >= AF_LEVEL   (1..DEPTH)
//   AE_LEVEL    almost_empty_o when count <= AE_LEVEL  (0..DEPTH-1)
//
// Ports:
//   clock_i         rising-edge clock
//   reset_n_i       asynchronous active-low reset
//   clear_i         synchronous flush, overrides all requests
//   write_inc_i     write request, data_i stored if accepted
//   data_i          write data
//   read_inc_i      read/pop request
//   data_o          read data
//   full_o          count == DEPTH
//   almost_full_o   count >= AF_LEVEL
//   empty_o         count == 0
//   almost_empty_o  count <= AE_LEVEL
//   count_o         occupancy, 0..DEPTH
//   overflow_o      sticky: write refused
//   underflow_o     sticky: read refused
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  clear_i,
  input  logic                  write_inc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  read_inc_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Thresholds sized to the count register so all compares are same-width.
  localparam logic [ADDR_WIDTH:0] C_DEPTH    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF_LEVEL = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_AE_LEVEL = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] C_ONE      = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

  // Storage (not reset).
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_mem_we;

  // All status decodes from the registered count only.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A read frees a slot in the same edge, so a full FIFO still accepts a
  // write when it is being popped at the same time.
  assign w_rd_ok = read_inc_i & ~w_empty;
  assign w_wr_ok = write_inc_i & (~w_full | w_rd_ok);

  // A flush discards the write of its cycle; reset kills an in-flight write.
  assign w_mem_we = w_wr_ok & ~clear_i & reset_n_i;

  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (r_count >= C_AF_LEVEL);
  assign almost_empty_o = (r_count <= C_AE_LEVEL);
  assign count_o        = r_count;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

  always_ff @(posedge clock_i) begin
    if (w_mem_we) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // Pointers wrap naturally modulo DEPTH; the count disambiguates full/empty.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      if (write_inc_i && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (read_inc_i && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown directly; forced to zero so an empty FIFO never
  // exposes stale memory contents.
  assign data_o = w_empty ? '0 : r_mem[r_rptr];
`else
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_data <= '0;
    end else if (clear_i) begin
      r_data <= '0;
    end else if (w_rd_ok) begin
      r_data <= r_mem[r_rptr];
    end
  end

  assign data_o = r_data;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 14;
  localparam int AEL   = 2;

  logic          clk;
  logic          reset_n_i;
  logic          clear_i;
  logic          write_inc_i;
  logic [DW-1:0] data_i;
  logic          read_inc_i;
  logic [DW-1:0] data_o;
  logic          full_o;
  logic          almost_full_o;
  logic          empty_o;
  logic          almost_empty_o;
  logic [AW:0]   count_o;
  logic          overflow_o;
  logic          underflow_o;

  sync_fifo_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL(AFL),
    .AE_LEVEL(AEL)
  ) dut (
    .clock_i(clk),
    .reset_n_i(reset_n_i),
    .clear_i(clear_i),
    .write_inc_i(write_inc_i),
    .data_i(data_i),
    .read_inc_i(read_inc_i),
    .data_o(data_o),
    .full_o(full_o),
    .almost_full_o(almost_full_o),
    .empty_o(empty_o),
    .almost_empty_o(almost_empty_o),
    .count_o(count_o),
    .overflow_o(overflow_o),
    .underflow_o(underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: queue of stored words plus sticky flags.
  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_dreg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_dreg;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dreg = '0;
  endtask

  task automatic model_update(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
    bit was_full, was_empty, rd_acc, wr_acc;
    logic [DW-1:0] popped;
    if (c) begin
      model_reset();
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    rd_acc    = r && !was_empty;
    wr_acc    = w && (!was_full || rd_acc);
    if (r && !rd_acc) m_unf = 1'b1;
    if (w && !wr_acc) m_ovf = 1'b1;
    if (rd_acc) begin
      popped = q.pop_front();
      m_dreg = popped;
    end
    if (wr_acc) q.push_back(d);
  endtask

  task automatic step(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
    clear_i     = c;
    write_inc_i = w;
    data_i      = d;
    read_inc_i  = r;
    @(posedge clk);
    model_update(c, w, d, r);
    @(negedge clk);
    clear_i     = 1'b0;
    write_inc_i = 1'b0;
    read_inc_i  = 1'b0;
  endtask

  // Pops one word and checks it against a literal, respecting read latency.
  task automatic read_expect(input string name, input logic [DW-1:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk(name, 32'(data_o), 32'(exp));
    step(1'b0, 1'b0, '0, 1'b1);
`else
    step(1'b0, 1'b0, '0, 1'b1);
    chk(name, 32'(data_o), 32'(exp));
`endif
  endtask

  // Single compare process: every output against the model every cycle.
  always @(negedge clk) begin
    int n;
    if (cmp_en) begin
      n = q.size();
      chk("count",   32'(count_o),        32'(n));
      chk("empty",   32'(empty_o),        32'(n == 0));
      chk("full",    32'(full_o),         32'(n == DEPTH));
      chk("a_empty", 32'(almost_empty_o), 32'(n <= AEL));
      chk("a_full",  32'(almost_full_o),  32'(n >= AFL));
      chk("ovf",     32'(overflow_o),     32'(m_ovf));
      chk("unf",     32'(underflow_o),    32'(m_unf));
      chk("data",    32'(data_o),         32'(exp_data()));
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"},   32'(count_o),        0);
    chk({tag, "_empty"},   32'(empty_o),        1);
    chk({tag, "_a_empty"}, 32'(almost_empty_o), 1);
    chk({tag, "_full"},    32'(full_o),         0);
    chk({tag, "_a_full"},  32'(almost_full_o),  0);
    chk({tag, "_ovf"},     32'(overflow_o),     0);
    chk({tag, "_unf"},     32'(underflow_o),    0);
    chk({tag, "_data"},    32'(data_o),         0);
  endtask

  task automatic fill_seq();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, DW'(i), 1'b0);
    end
  endtask

  int wp, rp;

  initial begin
    reset_n_i   = 1'b0;
    clear_i     = 1'b0;
    write_inc_i = 1'b0;
    data_i      = '0;
    read_inc_i  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    reset_n_i = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Fill 0x01..0x10 with threshold pins.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, DW'(i), 1'b0);
      chk("fill_count", 32'(count_o), 32'(i));
      chk("fill_empty", 32'(empty_o), 0);
      if (i == 2)  chk("ae_at2", 32'(almost_empty_o), 1);
      if (i == 3)  chk("ae_at3", 32'(almost_empty_o), 0);
      if (i == 13) chk("af_at13", 32'(almost_full_o), 0);
      if (i == 14) chk("af_at14", 32'(almost_full_o), 1);
      if (i == 15) chk("full_at15", 32'(full_o), 0);
      if (i == 16) chk("full_at16", 32'(full_o), 1);
    end

    // 17th write refused.
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("ovf_set", 32'(overflow_o), 1);
    chk("ovf_count", 32'(count_o), 16);

    for (int i = 1; i <= DEPTH; i++) begin
      read_expect("drain", DW'(i));
    end
    chk("drain_empty", 32'(empty_o), 1);
    chk("drain_count", 32'(count_o), 0);
    chk("ovf_sticky", 32'(overflow_o), 1);

    // Full with simultaneous write and read.
    step(1'b1, 1'b0, '0, 1'b0);
    fill_seq();
`ifdef SYNC_FIFO_FWFT_EN
    chk("fr_head", 32'(data_o), 32'h01);
`endif
    step(1'b0, 1'b1, 8'h55, 1'b1);
    chk("fr_count", 32'(count_o), 16);
    chk("fr_ovf", 32'(overflow_o), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("fr_data", 32'(data_o), 32'h01);
`endif
    for (int i = 2; i <= DEPTH; i++) begin
      read_expect("fr_seq", DW'(i));
    end
    read_expect("fr_last", 8'h55);

    // Empty with simultaneous write and read.
    step(1'b0, 1'b1, 8'h33, 1'b1);
    chk("er_unf", 32'(underflow_o), 1);
    chk("er_count", 32'(count_o), 1);
    read_expect("er_data", 8'h33);

    // 20 words across the pointer wrap, overlapping write and read.
    step(1'b1, 1'b0, '0, 1'b0);
    wp = 0;
    rp = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, DW'(8'hC0 + wp), 1'b0);
      wp++;
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, DW'(8'hC0 + wp), 1'b1);
      wp++;
      rp++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      rp++;
    end
    chk("wrap_rp", 32'(rp), 20);
    chk("wrap_empty", 32'(empty_o), 1);
    chk("wrap_ovf", 32'(overflow_o), 0);
    chk("wrap_unf", 32'(underflow_o), 0);

    // Five words stored with overflow set, then clear together with a write.
    fill_seq();
    step(1'b0, 1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("cl_pre_count", 32'(count_o), 5);
    chk("cl_pre_ovf", 32'(overflow_o), 1);
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("cl_count", 32'(count_o), 0);
    chk("cl_empty", 32'(empty_o), 1);
    chk("cl_ovf", 32'(overflow_o), 0);
    chk("cl_data", 32'(data_o), 0);
    step(1'b0, 1'b1, 8'h01, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_show", 32'(data_o), 32'h01);
`else
    chk("std_hold", 32'(data_o), 0);
`endif
    read_expect("cl_after", 8'h01);

    // Randomised phases biased towards full, empty and balanced traffic.
    for (int ph = 0; ph < 12; ph++) begin
      int wpct, rpct;
      case (ph % 3)
        0:       begin wpct = 80; rpct = 25; end
        1:       begin wpct = 20; rpct = 80; end
        default: begin wpct = 55; rpct = 55; end
      endcase
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 149) == 0,
             $urandom_range(0, 99) < wpct,
             DW'($urandom),
             $urandom_range(0, 99) < rpct);
      end
    end

    // Asynchronous reset mid-operation with a write in flight.
    fill_seq();
    #2;
    cmp_en      = 1'b0;
    write_inc_i = 1'b1;
    data_i      = 8'h99;
    reset_n_i   = 1'b0;
    #1;
    check_reset_values("arst");
    model_reset();
    @(negedge clk);
    write_inc_i = 1'b0;
    reset_n_i   = 1'b1;
    cmp_en      = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    chk("arst_after", 32'(count_o), 0);
    step(1'b0, 1'b1, 8'h5A, 1'b0);
    read_expect("arst_rd", 8'h5A);

    cmp_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
